score_bcd_encoder: RTL and testbench

//  Producer side of the score display path. Accumulates the game score from pellet/power events.

---
 rtl/score_pkg.sv | 19 +
 rtl/score_bcd_encoder_if.sv | 26 ++
 rtl/bcd_add3.sv | 12 +
 rtl/score_bcd_encoder.sv | 126 ++++++++++++
 tb/tb_score_bcd_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared constants and types for the score display path; the game-logic block
// imports the same point values so both sides agree on scoring.
package score_pkg;

    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_SCORE_W    = 14;
    localparam int PELLET_PTS     = 10;
    localparam int POWER_PTS      = 50;
    localparam int SCORE_MAX      = 10**DEF_NUM_DIGITS - 1;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } fsm_state_t;

endpackage

// File: rtl/score_bcd_encoder_if.sv
// Event inputs and display outputs between the game logic (master) and the
// score encoder (slave).
interface score_bcd_encoder_if #(
    parameter int NUM_DIGITS = score_pkg::DEF_NUM_DIGITS,
    parameter int SCORE_W    = score_pkg::DEF_SCORE_W
);

    logic                    pellet_eaten;
    logic                    power_eaten;
    logic                    clear_score;
    logic                    frame_start;
    logic [SCORE_W-1:0]      score_bin;
    logic [4*NUM_DIGITS-1:0] score_digits;
    logic                    busy;

    modport master (
        output pellet_eaten, power_eaten, clear_score, frame_start,
        input  score_bin, score_digits, busy
    );

    modport slave (
        input  pellet_eaten, power_eaten, clear_score, frame_start,
        output score_bin, score_digits, busy
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import score_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t corrected
);

    assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/score_bcd_encoder.sv
// Score accumulator, sequential binary-to-BCD converter and frame-synchronous
// display register; digits only move on frame_start so glyphs never tear.
module score_bcd_encoder #(
    parameter int NUM_DIGITS = score_pkg::DEF_NUM_DIGITS,
    parameter int SCORE_W    = score_pkg::DEF_SCORE_W,
    parameter int PELLET_PTS = score_pkg::PELLET_PTS,
    parameter int POWER_PTS  = score_pkg::POWER_PTS
) (
    input  logic                Clk,
    input  logic                Reset_n,
    score_bcd_encoder_if.slave  bus
);

    import score_pkg::*;

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam int          SR_W      = BCD_W + SCORE_W;
    localparam int          CNT_W     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(SCORE_W - 1);
    localparam logic [31:0] SAT_LIMIT = 32'(10**NUM_DIGITS - 1);

    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_next;
    logic [31:0]        sum_wide;
    logic               score_changed;
    logic               dirty;

    fsm_state_t         state;
    logic [SR_W-1:0]    shift_reg;
    logic [CNT_W-1:0]   iter_cnt;
    logic [BCD_W-1:0]   corrected_bcd;
    logic [BCD_W-1:0]   pending_bcd;
    logic               pending;
    logic [BCD_W-1:0]   digits_q;

    // Sum in a wide domain so the saturation compare never sees a wrapped value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sum_wide   = 32'(score_q);
        score_next = score_q;
        if (bus.pellet_eaten) sum_wide = sum_wide + 32'(PELLET_PTS);
        if (bus.power_eaten)  sum_wide = sum_wide + 32'(POWER_PTS);
        if (bus.clear_score)
            score_next = '0;
        else if (sum_wide > SAT_LIMIT)
            score_next = SCORE_W'(SAT_LIMIT);
        else
            score_next = SCORE_W'(sum_wide);
    end

    assign score_changed = (score_next != score_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            score_q <= score_next;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit     (shift_reg[SCORE_W + 4*i +: 4]),
            .corrected (corrected_bcd[4*i +: 4])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the result/display registers are small flops, not RAM, so they are
            // all reset; a reset mid-conversion must leave nothing behind.
            state       <= IDLE;
            shift_reg   <= '0;
            iter_cnt    <= '0;
            dirty       <= 1'b0;
            pending     <= 1'b0;
            pending_bcd <= '0;
            digits_q    <= '0;
        end else begin
            // Commit uses the pre-edge pending flag, so a result landing in DONE this
            // same cycle waits for the next frame.
            if (bus.frame_start && pending) begin
                digits_q <= pending_bcd;
                pending  <= 1'b0;
            end

            // A score change always re-arms dirty, even in the snapshot cycle.
            if (score_changed)
                dirty <= 1'b1;
            else if (state == IDLE)
                dirty <= 1'b0;

            case (state)
                IDLE: begin
                    if (dirty) begin
                        shift_reg <= {{BCD_W{1'b0}}, score_q};
                        iter_cnt  <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= {corrected_bcd, shift_reg[SCORE_W-1:0]} << 1;
                    iter_cnt  <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER)
                        state <= DONE;
                end
                DONE: begin
                    pending_bcd <= shift_reg[SR_W-1 -: BCD_W];
                    pending     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.score_bin    = score_q;
    assign bus.score_digits = digits_q;
    assign bus.busy         = (state != IDLE);

    score_never_exceeds_max: assert property (
        @(posedge Clk) disable iff (!Reset_n) 32'(score_q) <= SAT_LIMIT
    );

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Self-checking bench for score_bcd_encoder: directed scenarios plus a random
// event stream checked against a decimal-arithmetic score model.
module tb_score_bcd_encoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    score_bcd_encoder_if #(.NUM_DIGITS(4), .SCORE_W(14)) bus ();

    score_bcd_encoder #(
        .NUM_DIGITS (4),
        .SCORE_W    (14),
        .PELLET_PTS (10),
        .POWER_PTS  (50)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int model_score = 0;
    bit seen [0:9999];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Returns -1 for any nibble that is not a decimal digit.
    function automatic int from_bcd(input logic [15:0] d);
        int v;
        v = 0;
        for (int k = 3; k >= 0; k--) begin
            if ($isunknown(d[4*k +: 4]) || d[4*k +: 4] > 4'd9) return -1;
            v = v * 10 + int'(d[4*k +: 4]);
        end
        return v;
    endfunction

    function automatic void model_step(input bit p, input bit w, input bit c);
        if (c)
            model_score = 0;
        else begin
            model_score = model_score + (p ? 10 : 0) + (w ? 50 : 0);
            if (model_score > 9999) model_score = 9999;
        end
        seen[model_score] = 1'b1;
    endfunction

    task automatic idle_inputs();
        bus.pellet_eaten = 1'b0;
        bus.power_eaten  = 1'b0;
        bus.clear_score  = 1'b0;
        bus.frame_start  = 1'b0;
    endtask

    // One-cycle event pulse; returns at the negedge after the consuming edge.
    task automatic drive(input bit p, input bit w, input bit c);
        @(negedge clk);
        bus.pellet_eaten = p;
        bus.power_eaten  = w;
        bus.clear_score  = c;
        @(negedge clk);
        idle_inputs();
        model_step(p, w, c);
    endtask

    task automatic frame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    // Idle means busy low on two consecutive samples, so a queued rerun is caught.
    task automatic wait_idle(input string tag);
        int low;
        low = 0;
        for (int c = 0; c < 300 && low < 2; c++) begin
            @(negedge clk);
            low = bus.busy ? 0 : low + 1;
        end
        checks++;
        if (low < 2) begin
            failures++;
            $display("FAIL %s_wait_idle: busy=%0b, required 0 within 300 cycles", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.score_bin !== 14'd0) begin
            failures++; $display("FAIL reset_score_bin: got %0d, required 0", bus.score_bin);
        end
        checks++;
        if (bus.score_digits !== 16'h0000) begin
            failures++; $display("FAIL reset_digits: got %h, required 0000", bus.score_digits);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_score = 0;
        seen[0] = 1'b1;
    endtask

    task automatic test_single_pellet();
        int n;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.score_bin !== 14'(model_score) || model_score != 10) begin
            failures++; $display("FAIL pellet_score_bin: got %0d, required 10", bus.score_bin);
        end
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n != 15) begin
            failures++; $display("FAIL pellet_busy_len: got %0d cycles, required 15", n);
        end
        checks++;
        if (bus.score_digits !== 16'h0000) begin
            failures++; $display("FAIL pellet_precommit: got %h, required 0000", bus.score_digits);
        end
        frame();
        checks++;
        if (bus.score_digits !== 16'h0010) begin
            failures++; $display("FAIL pellet_commit: got %h, required 0010", bus.score_digits);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.score_bin !== 14'd60) begin
            failures++; $display("FAIL simul_score_bin: got %0d, required 60", bus.score_bin);
        end
        wait_idle("simul");
        frame();
        checks++;
        if (bus.score_digits !== to_bcd(model_score)) begin
            failures++; $display("FAIL simul_commit: got %h, required %h", bus.score_digits, to_bcd(model_score));
        end
    endtask

    task automatic test_frame_gating();
        drive(1'b0, 1'b0, 1'b1);
        wait_idle("gate_clr");
        frame();
        checks++;
        if (bus.score_digits !== 16'h0000) begin
            failures++; $display("FAIL gate_cleared: got %h, required 0000", bus.score_digits);
        end
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL gate_busy: got %b, required 1", bus.busy);
        end
        frame();
        checks++;
        if (bus.score_digits !== 16'h0000) begin
            failures++; $display("FAIL gate_while_busy: got %h, required 0000", bus.score_digits);
        end
        wait_idle("gate");
        frame();
        checks++;
        if (bus.score_digits !== 16'h0010) begin
            failures++; $display("FAIL gate_after_done: got %h, required 0010", bus.score_digits);
        end
        // frame_start landing exactly in the DONE cycle must not commit.
        drive(1'b1, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL gate_done_busy: got %b, required 1", bus.busy);
        end
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.score_digits !== 16'h0010) begin
            failures++;
            $display("FAIL gate_done_coincide: busy=%b digits=%h, required busy=0 digits=0010",
                     bus.busy, bus.score_digits);
        end
        frame();
        checks++;
        if (bus.score_digits !== 16'h0020) begin
            failures++; $display("FAIL gate_next_frame: got %h, required 0020", bus.score_digits);
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)  drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.score_bin !== 14'd1230) begin
            failures++; $display("FAIL clr_setup: got %0d, required 1230", bus.score_bin);
        end
        wait_idle("clr_setup");
        frame();
        checks++;
        if (bus.score_digits !== 16'h1230) begin
            failures++; $display("FAIL clr_setup_commit: got %h, required 1230", bus.score_digits);
        end
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.score_bin !== 14'd0) begin
            failures++; $display("FAIL clr_priority: got %0d, required 0", bus.score_bin);
        end
        wait_idle("clr");
        frame();
        checks++;
        if (bus.score_digits !== 16'h0000) begin
            failures++; $display("FAIL clr_commit: got %h, required 0000", bus.score_digits);
        end
        // Second event arrives mid-SHIFT; the final commit must track it.
        drive(1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        drive(1'b1, 1'b0, 1'b0);
        wait_idle("rerun");
        frame();
        checks++;
        if (bus.score_digits !== 16'h0020) begin
            failures++; $display("FAIL rerun_commit: got %h, required 0020", bus.score_digits);
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 199; i++) drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)   drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.score_bin !== 14'd9999) begin
            failures++; $display("FAIL sat_reach: got %0d, required 9999", bus.score_bin);
        end
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.score_bin !== 14'd9999) begin
            failures++; $display("FAIL sat_hold: got %0d, required 9999", bus.score_bin);
        end
        wait_idle("sat");
        frame();
        checks++;
        if (bus.score_digits !== 16'h9999) begin
            failures++; $display("FAIL sat_commit: got %h, required 9999", bus.score_digits);
        end
    endtask

    task automatic test_reset_mid_shift();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        wait_idle("rst_prep");
        drive(1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL rst_mid_busy_before: got %b, required 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.score_bin !== 14'd0 || bus.score_digits !== 16'h0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs: score=%0d digits=%h busy=%b, required 0/0000/0",
                     bus.score_bin, bus.score_digits, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_score = 0;
        frame();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.score_digits !== 16'h0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_no_commit: digits=%h busy=%b, required 0000/0",
                     bus.score_digits, bus.busy);
        end
    endtask

    task automatic test_random();
        bit p, w, c, f;
        int d;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[model_score] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 7) == 0);
            bus.pellet_eaten = p;
            bus.power_eaten  = w;
            bus.clear_score  = c;
            bus.frame_start  = f;
            @(negedge clk);
            model_step(p, w, c);
            checks++;
            if (bus.score_bin !== 14'(model_score)) begin
                failures++;
                $display("FAIL rand_score_bin[%0d]: got %0d, required %0d", i, bus.score_bin, model_score);
            end
            d = from_bcd(bus.score_digits);
            checks++;
            if (d < 0) begin
                failures++;
                $display("FAIL rand_digits_bcd[%0d]: got %h, required valid BCD", i, bus.score_digits);
            end else if (!seen[d]) begin
                failures++;
                $display("FAIL rand_digits_value[%0d]: got %h, required a score that occurred", i, bus.score_digits);
            end
        end
        idle_inputs();
        wait_idle("rand");
        frame();
        checks++;
        if (bus.score_digits !== to_bcd(model_score)) begin
            failures++;
            $display("FAIL rand_final: got %h, required %h", bus.score_digits, to_bcd(model_score));
        end
    endtask

    initial begin
        test_reset();
        test_single_pellet();
        test_simultaneous();
        test_frame_gating();
        test_clear_priority();
        test_saturation();
        test_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
